// File: rtl/sram_uart_tx_pkg.sv
// Shared state encodings and defaults for the SRAM-to-UART return path.
package sram_uart_tx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT      = 434;
  localparam int DEFAULT_SRAM_READ_LATENCY = 2;
  localparam int UART_FRAME_BITS           = 10;

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_READ,
    S_TX_WAIT,
    S_TX_HIGH,
    S_TX_LOW,
    S_TX_CHECKSUM,
    S_TX_DONE
  } tx_state_type;

  typedef enum logic [2:0] {
    S_TOP_IDLE,
    S_ENABLE_UART_RX,
    S_WAIT_UART_RX,
    S_DECODE,
    S_UART_TX
  } top_state_type;

  // Words go out high byte first.
  function automatic logic [7:0] frame_byte(input logic [15:0] word, input logic high);
    return high ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 byte serializer with a valid/ready handshake; ready also rises in the
// last stop-bit cycle so consecutive frames can run back-to-back.
module uart_tx_serializer
  import sram_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       tx_line
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] BIT_LAST = 4'(UART_FRAME_BITS - 1);

  logic              busy_reg;
  logic [BAUD_W-1:0] baud_cnt_reg;
  logic [3:0]        bit_cnt_reg;
  logic [8:0]        shift_reg;
  logic              tx_reg;
  logic              bit_end;
  logic              accept;

  assign bit_end    = (baud_cnt_reg == BAUD_LAST);
  assign byte_ready = !busy_reg || (bit_end && (bit_cnt_reg == BIT_LAST));
  assign accept     = byte_valid && byte_ready;
  assign tx_line    = tx_reg;

  // shift_reg holds the data bits still to send with the stop bit on top.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      busy_reg     <= 1'b0;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '1;
      tx_reg       <= 1'b1;
    end else if (accept) begin
      busy_reg     <= 1'b1;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= {1'b1, byte_data};
      tx_reg       <= 1'b0;
    end else if (busy_reg) begin
      if (bit_end) begin
        baud_cnt_reg <= '0;
        if (bit_cnt_reg == BIT_LAST) begin
          busy_reg <= 1'b0;
          tx_reg   <= 1'b1;
        end else begin
          tx_reg      <= shift_reg[0];
          shift_reg   <= {1'b1, shift_reg[8:1]};
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
      end else begin
        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
      end
    end
  end

endmodule

// File: rtl/sram_uart_tx.sv
// Reads a block of 16-bit SRAM words and streams them out as 8N1 bytes, high byte first.
// Define UART_TX_CHECKSUM_EN to append an XOR checksum frame after the last word.
module sram_uart_tx
  import sram_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT      = DEFAULT_CLKS_PER_BIT,
  parameter int SRAM_READ_LATENCY = DEFAULT_SRAM_READ_LATENCY
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [17:0] Base_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  localparam int WAIT_W = (SRAM_READ_LATENCY > 1) ? $clog2(SRAM_READ_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SRAM_READ_LATENCY - 1);

  tx_state_type      state_reg;
  tx_state_type      state_next;
  logic [17:0]       addr_reg;
  logic [17:0]       remaining_reg;
  logic [17:0]       sram_address_reg;
  logic [15:0]       word_buf;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              done_reg;
  logic              last_word;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
`ifdef UART_TX_CHECKSUM_EN
  logic [7:0]        checksum_reg;
`endif

  assign SRAM_we_n    = 1'b1;
  assign SRAM_address = sram_address_reg;
  assign Done         = done_reg;
  assign last_word    = (remaining_reg == 18'd1);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg <= S_TX_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_TX_IDLE: begin
        if (Start) begin
          state_next = (Word_count == '0) ? S_TX_DONE : S_TX_READ;
        end
      end
      S_TX_READ: state_next = S_TX_WAIT;
      S_TX_WAIT: begin
        if (wait_cnt_reg == WAIT_LAST) begin
          state_next = S_TX_HIGH;
        end
      end
      S_TX_HIGH: begin
        if (byte_ready) begin
          state_next = S_TX_LOW;
        end
      end
      S_TX_LOW: begin
        if (byte_ready) begin
          if (last_word) begin
`ifdef UART_TX_CHECKSUM_EN
            state_next = S_TX_CHECKSUM;
`else
            state_next = S_TX_DONE;
`endif
          end else begin
            state_next = S_TX_READ;
          end
        end
      end
`ifdef UART_TX_CHECKSUM_EN
      S_TX_CHECKSUM: begin
        if (byte_ready) begin
          state_next = S_TX_DONE;
        end
      end
`endif
      S_TX_DONE: begin
        if (byte_ready) begin
          state_next = S_TX_IDLE;
        end
      end
      default: state_next = S_TX_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = 1'b0;
    byte_data  = frame_byte(word_buf, 1'b1);
    Busy       = (state_reg != S_TX_IDLE);
    case (state_reg)
      S_TX_HIGH: begin
        byte_valid = 1'b1;
        byte_data  = frame_byte(word_buf, 1'b1);
      end
      S_TX_LOW: begin
        byte_valid = 1'b1;
        byte_data  = frame_byte(word_buf, 1'b0);
      end
`ifdef UART_TX_CHECKSUM_EN
      S_TX_CHECKSUM: begin
        byte_valid = 1'b1;
        byte_data  = checksum_reg;
      end
`endif
      default: ;
    endcase
  end

  // The next word's address is issued while its predecessor's low byte is on
  // the line, which keeps frames back-to-back.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      addr_reg         <= '0;
      remaining_reg    <= '0;
      sram_address_reg <= '0;
      word_buf         <= '0;
      wait_cnt_reg     <= '0;
      done_reg         <= 1'b0;
    end else begin
      done_reg <= (state_reg == S_TX_DONE) && byte_ready;
      case (state_reg)
        S_TX_IDLE: begin
          if (Start) begin
            addr_reg      <= Base_address;
            remaining_reg <= Word_count;
            if (Word_count != '0) begin
              sram_address_reg <= Base_address;
            end
          end
        end
        S_TX_READ: wait_cnt_reg <= '0;
        S_TX_WAIT: begin
          wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          if (wait_cnt_reg == WAIT_LAST) begin
            word_buf <= SRAM_read_data;
          end
        end
        S_TX_LOW: begin
          if (byte_ready) begin
            remaining_reg <= remaining_reg - 18'd1;
            addr_reg      <= addr_reg + 18'd1;
            if (!last_word) begin
              sram_address_reg <= addr_reg + 18'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UART_TX_CHECKSUM_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      checksum_reg <= '0;
    end else if ((state_reg == S_TX_IDLE) && Start) begin
      checksum_reg <= '0;
    end else if (((state_reg == S_TX_HIGH) || (state_reg == S_TX_LOW)) && byte_ready) begin
      checksum_reg <= checksum_reg ^ byte_data;
    end
  end
`endif

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializer (
    .Clock     (Clock),
    .Reset     (Reset),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .tx_line   (UART_TX_O)
  );

endmodule

// File: tb/tb_sram_uart_tx.sv
// Directed plus randomized bench for sram_uart_tx against a frame-level line model.
module tb_sram_uart_tx;

  localparam int CPB   = 4;
  localparam int LAT   = 2;
  localparam int FRAME = 10 * CPB;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [17:0] Base_address;
  logic [17:0] Word_count;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;

  logic [15:0] mem [0:262143];
  logic [15:0] sram_d1;
  logic [15:0] sram_d2;

  int checks = 0;
  int errors = 0;

  sram_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .SRAM_READ_LATENCY(LAT)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Start         (Start),
    .Base_address  (Base_address),
    .Word_count    (Word_count),
    .SRAM_address  (SRAM_address),
    .SRAM_we_n     (SRAM_we_n),
    .SRAM_read_data(SRAM_read_data),
    .UART_TX_O     (UART_TX_O),
    .Busy          (Busy),
    .Done          (Done)
  );

  always #5 Clock = ~Clock;

  // Two-cycle read latency SRAM model.
  always @(posedge Clock) begin
    sram_d1 <= mem[SRAM_address];
    sram_d2 <= sram_d1;
  end
  assign SRAM_read_data = sram_d2;

  task automatic chk(input string tag, input int k, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // Runs one transfer; cycle k counts from the cycle after the Start pulse.
  task automatic transfer(input logic [17:0] base, input logic [17:0] cnt, input int restart_at);
    logic [7:0]  bytes_q[$];
    logic [17:0] addr_q[$];
    logic [17:0] a;
    logic [17:0] addr_before;
    logic [7:0]  cur;
    logic [7:0]  xsum;
    logic        exp_line;
    int frames, done_k, b, f, pos, j;
    xsum = 8'h00;
    for (int i = 0; i < int'(cnt); i++) begin
      a = base + 18'(i);
      addr_q.push_back(a);
      bytes_q.push_back(mem[a][15:8]);
      bytes_q.push_back(mem[a][7:0]);
      xsum = xsum ^ mem[a][15:8] ^ mem[a][7:0];
    end
`ifdef UART_TX_CHECKSUM_EN
    if (cnt != 0) bytes_q.push_back(xsum);
`endif
    frames = bytes_q.size();
    done_k = (frames == 0) ? 2 : 5 + FRAME * frames;

    @(negedge Clock);
    addr_before  = SRAM_address;
    Start        = 1'b1;
    Base_address = base;
    Word_count   = cnt;
    @(posedge Clock); #1;
    Start = 1'b0;
    for (int k = 1; k <= done_k + 1; k++) begin
      exp_line = 1'b1;
      if (k >= 5 && k < 5 + FRAME * frames) begin
        b   = (k - 5) / CPB;
        f   = b / 10;
        pos = b % 10;
        cur = bytes_q[f];
        if (pos == 0) exp_line = 1'b0;
        else if (pos == 9) exp_line = 1'b1;
        else exp_line = cur[pos-1];
      end
      chk("line", k, 18'(UART_TX_O), 18'(exp_line));
      chk("busy", k, 18'(Busy), 18'(k < done_k));
      chk("done", k, 18'(Done), 18'(k == done_k));
      if (cnt == 0) begin
        chk("addr_hold", k, SRAM_address, addr_before);
      end else begin
        j = -1;
        if (k == 1) j = 0;
        else if (k > 5 && ((k - 5) % (2 * FRAME)) == FRAME) j = (k - 5 + FRAME) / (2 * FRAME);
        if (j >= 0 && j < int'(cnt)) chk("read_addr", k, SRAM_address, addr_q[j]);
      end
      if (k == restart_at) begin
        Start        = 1'b1;
        Base_address = base ^ 18'h00155;
        Word_count   = 18'd7;
      end else begin
        Start = 1'b0;
      end
      @(posedge Clock); #1;
    end
    $display("txn base=%0d count=%0d frames=%0d restart_at=%0d errors_so_far=%0d",
             base, cnt, frames, restart_at, errors);
  endtask

  initial begin
    Reset        = 1'b1;
    Start        = 1'b0;
    Base_address = '0;
    Word_count   = '0;
    for (int i = 0; i < 262144; i++) mem[i] = 16'($urandom);
    mem[100]  = 16'hA55A;
    mem[500]  = 16'h0000;
    mem[1000] = 16'h1234;
    mem[1001] = 16'hFF00;

    repeat (3) @(posedge Clock);
    #1;
    chk("rst_line", 0, 18'(UART_TX_O), 18'd1);
    chk("rst_addr", 0, SRAM_address, 18'd0);
    chk("rst_we_n", 0, 18'(SRAM_we_n), 18'd1);
    chk("rst_busy", 0, 18'(Busy), 18'd0);
    chk("rst_done", 0, 18'(Done), 18'd0);
    @(negedge Clock);
    Reset = 1'b0;

    transfer(18'd100, 18'd1, 0);
    transfer(18'd262142, 18'd3, 0);
    transfer(18'd7, 18'd0, 0);
    transfer(18'd300, 18'd2, 20);

    // Reset in the middle of a data bit of an all-zero high byte.
    @(negedge Clock);
    Start        = 1'b1;
    Base_address = 18'd500;
    Word_count   = 18'd2;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (17) @(posedge Clock);
    #1;
    chk("pre_reset_line", 18, 18'(UART_TX_O), 18'd0);
    Reset = 1'b1;
    #1;
    chk("async_rst_line", 18, 18'(UART_TX_O), 18'd1);
    chk("async_rst_busy", 18, 18'(Busy), 18'd0);
    chk("async_rst_done", 18, 18'(Done), 18'd0);
    chk("async_rst_addr", 18, SRAM_address, 18'd0);
    $display("txn reset mid-frame base=500 count=2 errors_so_far=%0d", errors);
    @(negedge Clock);
    Reset = 1'b0;

    transfer(18'd500, 18'd2, 0);
    transfer(18'd1000, 18'd2, 0);
    for (int i = 0; i < 4; i++) begin
      transfer(18'($urandom_range(0, 262143)), 18'($urandom_range(1, 3)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
